// File: rtl/vga_frame_ctrl_if.sv
// Raster timing and conditioned trigger bundle between vga_frame_ctrl (master)
// and the downstream pattern generator (slave).
interface vga_frame_ctrl_if;
  logic       trigger_raw;
  logic       hsync;
  logic       vsync;
  logic       valid;
  logic [9:0] col;
  logic [9:0] row;
  logic       screen_reset;
  logic       trigger;

  modport master (
    input  trigger_raw,
    output hsync, vsync, valid, col, row, screen_reset, trigger
  );

  modport slave (
    output trigger_raw,
    input  hsync, vsync, valid, col, row, screen_reset, trigger
  );
endinterface

// File: rtl/vga_frame_ctrl.sv
// Free-running VGA raster generator with per-frame strobe and a synchronised,
// debounced, frame-aligned gun trigger.
module vga_frame_ctrl #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FP            = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BP            = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FP            = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 33,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             rst,
  vga_frame_ctrl_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [9:0]      hcnt_q, hcnt_d;
  logic [9:0]      vcnt_q, vcnt_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            valid_q, valid_d;
  logic            sr_q, sr_d;
  logic            trig_q, trig_d;
  logic [1:0]      sync_q;
  logic            deb_q, deb_d;
  logic [DB_W-1:0] dcnt_q, dcnt_d;
  logic            frame_start_d;

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
    end
  end

  // Flags decode the next counts so they register alongside col/row.
  always_comb begin
    valid_d       = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
    hsync_d       = !((hcnt_d >= HS_START) && (hcnt_d < HS_END));
    vsync_d       = !((vcnt_d >= VS_START) && (vcnt_d < VS_END));
    sr_d          = (hcnt_d == '0) && (vcnt_d == V_ACT);
    frame_start_d = (hcnt_d == '0) && (vcnt_d == '0);
  end

  // Trigger samples the pre-update debounced level, so a toggle landing on
  // the frame-start clock shows up one frame later.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (dcnt_q == DB_LAST) begin
        deb_d = sync_q[1];
      end else begin
        dcnt_d = dcnt_q + DB_W'(1);
      end
    end
    trig_d = frame_start_d ? deb_q : trig_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q  <= H_LAST;
      vcnt_q  <= V_LAST;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      valid_q <= 1'b0;
      sr_q    <= 1'b0;
      trig_q  <= 1'b0;
      sync_q  <= '0;
      deb_q   <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      valid_q <= valid_d;
      sr_q    <= sr_d;
      trig_q  <= trig_d;
      sync_q  <= {sync_q[0], bus.trigger_raw};
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign bus.hsync        = hsync_q;
  assign bus.vsync        = vsync_q;
  assign bus.valid        = valid_q;
  assign bus.col          = hcnt_q;
  assign bus.row          = vcnt_q;
  assign bus.screen_reset = sr_q;
  assign bus.trigger      = trig_q;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Bench for vga_frame_ctrl on a scaled-down raster, checked cycle by cycle
// against an arithmetic position model and a run-length debounce model.
module tb_vga_frame_ctrl;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int DB = 8;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vl;
    logic [9:0] col;
    logic [9:0] row;
    logic       sr;
    logic       tr;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  vga_frame_ctrl_if vif ();

  vga_frame_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Model: m_t counts clock edges since reset release (-1 = reset state).
  longint m_t;
  logic   m_s1, m_s2, m_lvl, m_trig;
  int     m_run;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_t <= -1; m_s1 <= 1'b0; m_s2 <= 1'b0; m_lvl <= 1'b0; m_trig <= 1'b0; m_run <= 0;
    end else begin
      m_t <= m_t + 1;
      if ((m_t + 1) % FRAME == 0) m_trig <= m_lvl;
      if (m_s2 !== m_lvl) begin
        if (m_run + 1 == DB) begin m_lvl <= m_s2; m_run <= 0; end
        else m_run <= m_run + 1;
      end else m_run <= 0;
      m_s2 <= m_s1;
      m_s1 <= vif.trigger_raw;
    end
  end

  function automatic int m_idx();
    return int'((m_t + FRAME) % FRAME);
  endfunction
  function automatic int m_col(); return m_idx() % HT; endfunction
  function automatic int m_row(); return m_idx() / HT; endfunction

  function automatic out_t model_exp();
    out_t e;
    int c, r;
    c = m_col(); r = m_row();
    e.col = 10'(c);
    e.row = 10'(r);
    if (m_t < 0) begin
      e.hs = 1'b1; e.vs = 1'b1; e.vl = 1'b0; e.sr = 1'b0;
    end else begin
      e.vl = (c < HA) && (r < VA);
      e.hs = !((c >= HA + HF) && (c < HA + HF + HS));
      e.vs = !((r >= VA + VF) && (r < VA + VF + VS));
      e.sr = (c == 0) && (r == VA);
    end
    e.tr = m_trig;
    return e;
  endfunction

  function automatic out_t reset_vals();
    out_t e;
    e.hs = 1'b1; e.vs = 1'b1; e.vl = 1'b0; e.sr = 1'b0; e.tr = 1'b0;
    e.col = 10'(HT - 1); e.row = 10'(VT - 1);
    return e;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.hs = vif.hsync; o.vs = vif.vsync; o.vl = vif.valid;
    o.col = vif.col; o.row = vif.row; o.sr = vif.screen_reset; o.tr = vif.trigger;
    return o;
  endfunction

  task automatic wait_pos(input int c, input int r);
    int n;
    n = 0;
    while (!(m_col() == c && m_row() == r) && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2 * FRAME) begin
      failures++;
      $display("FAIL wait_pos: (%0d,%0d) not reached, got (%0d,%0d) required (%0d,%0d)",
               c, r, m_col(), m_row(), c, r);
    end
  endtask

  task automatic test_reset();
    out_t o, e;
    rst = 1'b0;
    vif.trigger_raw = 1'b0;
    repeat (5) @(negedge clk);
    o = observe(); e = reset_vals(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_values: got %h required %h", o, e); end
    rst = 1'b1;
    @(negedge clk);
    e = reset_vals(); e.col = '0; e.row = '0; e.vl = 1'b1;
    o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL first_edge: got %h required %h", o, e); end
    for (int c = 1; c <= HA; c++) begin
      @(negedge clk);
      o = observe(); e = model_exp(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_walk c=%0d: got %h required %h", c, o, e); end
      if (c == HA - 1) begin
        checks++;
        if (vif.valid !== 1'b1) begin failures++; $display("FAIL valid_last_col: got %b required 1", vif.valid); end
      end
      if (c == HA) begin
        checks++;
        if (vif.valid !== 1'b0) begin failures++; $display("FAIL valid_past_col: got %b required 0", vif.valid); end
      end
    end
  endtask

  task automatic test_line_timing();
    out_t o, e;
    int lows, first;
    lows = 0; first = -1;
    wait_pos(0, 1);
    for (int i = 0; i < HT; i++) begin
      o = observe(); e = model_exp(); checks++;
      if (o !== e) begin failures++; $display("FAIL line i=%0d: got %h required %h", i, o, e); end
      if (vif.hsync === 1'b0) begin
        lows++;
        if (first < 0) first = i;
      end
      @(negedge clk);
    end
    checks++;
    if (lows != HS) begin failures++; $display("FAIL hsync_width: got %0d required %0d", lows, HS); end
    checks++;
    if (first != HA + HF) begin failures++; $display("FAIL hsync_start: got %0d required %0d", first, HA + HF); end
    checks++;
    if (vif.row !== 10'd2 || vif.col !== 10'd0) begin
      failures++; $display("FAIL row_inc: got (%0d,%0d) required (0,2)", vif.col, vif.row);
    end
  endtask

  task automatic test_frame_timing();
    out_t o, e;
    int sr_t[$];
    int vs_low, vl_cnt;
    vs_low = 0; vl_cnt = 0;
    wait_pos(0, 0);
    for (int i = 0; i < 3 * FRAME; i++) begin
      o = observe(); e = model_exp(); checks++;
      if (o !== e) begin failures++; $display("FAIL frame i=%0d: got %h required %h", i, o, e); end
      if (vif.screen_reset === 1'b1) begin
        sr_t.push_back(i);
        checks++;
        if (vif.col !== 10'd0 || vif.row !== 10'(VA)) begin
          failures++; $display("FAIL sr_pos: got (%0d,%0d) required (0,%0d)", vif.col, vif.row, VA);
        end
      end
      if (vif.vsync === 1'b0) vs_low++;
      if (vif.valid === 1'b1) vl_cnt++;
      @(negedge clk);
    end
    checks++;
    if (sr_t.size() != 3) begin failures++; $display("FAIL sr_count: got %0d required 3", sr_t.size()); end
    else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (sr_t[k] - sr_t[k-1] != FRAME) begin
          failures++; $display("FAIL sr_spacing: got %0d required %0d", sr_t[k] - sr_t[k-1], FRAME);
        end
      end
    end
    checks++;
    if (vs_low != 3 * VS * HT) begin failures++; $display("FAIL vsync_clocks: got %0d required %0d", vs_low, 3 * VS * HT); end
    checks++;
    if (vl_cnt != 3 * HA * VA) begin failures++; $display("FAIL valid_clocks: got %0d required %0d", vl_cnt, 3 * HA * VA); end
  endtask

  task automatic test_debounce_reject();
    out_t o, e;
    int hi_left, lo_left;
    hi_left = 0; lo_left = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (hi_left > 0) begin vif.trigger_raw = 1'b1; hi_left--; end
      else if (lo_left > 0) begin vif.trigger_raw = 1'b0; lo_left--; end
      else begin
        hi_left = $urandom_range(DB - 3, 1) - 1;
        lo_left = $urandom_range(12, 1);
        vif.trigger_raw = 1'b1;
      end
      @(negedge clk);
      o = observe(); e = model_exp(); checks++;
      if (o !== e) begin failures++; $display("FAIL reject i=%0d: got %h required %h", i, o, e); end
    end
    vif.trigger_raw = 1'b0;
    checks++;
    if (vif.trigger !== 1'b0) begin failures++; $display("FAIL reject_level: got %b required 0", vif.trigger); end
  endtask

  task automatic test_debounce_accept();
    out_t o, e;
    int n;
    wait_pos(0, 4);
    vif.trigger_raw = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
      o = observe(); e = model_exp(); checks++;
      if (o !== e) begin failures++; $display("FAIL accept_wait n=%0d: got %h required %h", n, o, e); end
    end while (m_idx() != 0 && n < 2 * FRAME);
    checks++;
    if (vif.trigger !== 1'b1) begin failures++; $display("FAIL accept_frame_start: got %b required 1", vif.trigger); end
    wait_pos(0, VA);
    checks++;
    if (vif.trigger !== 1'b1 || vif.screen_reset !== 1'b1) begin
      failures++; $display("FAIL accept_at_sr: got tr=%b sr=%b required tr=1 sr=1", vif.trigger, vif.screen_reset);
    end
    wait_pos(0, 8);
    vif.trigger_raw = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
      o = observe(); e = model_exp(); checks++;
      if (o !== e) begin failures++; $display("FAIL release_wait n=%0d: got %h required %h", n, o, e); end
    end while (m_idx() != 0 && n < 2 * FRAME);
    checks++;
    if (vif.trigger !== 1'b0) begin failures++; $display("FAIL release_frame_start: got %b required 0", vif.trigger); end
  endtask

  task automatic test_toggle_at_frame_start();
    out_t o, e;
    int n;
    n = 0;
    while (m_idx() != FRAME - DB - 2 && n < 2 * FRAME) begin @(negedge clk); n++; end
    if (n >= 2 * FRAME) begin failures++; $display("FAIL toggle_align: got idx %0d required %0d", m_idx(), FRAME - DB - 2); end
    vif.trigger_raw = 1'b1;
    for (int i = 0; i < DB + 2; i++) begin
      @(negedge clk);
      o = observe(); e = model_exp(); checks++;
      if (o !== e) begin failures++; $display("FAIL toggle_run i=%0d: got %h required %h", i, o, e); end
    end
    checks++;
    if (vif.col !== 10'd0 || vif.row !== 10'd0 || vif.trigger !== 1'b0) begin
      failures++; $display("FAIL toggle_pre_level: got (%0d,%0d) tr=%b required (0,0) tr=0", vif.col, vif.row, vif.trigger);
    end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      o = observe(); e = model_exp(); checks++;
      if (o !== e) begin failures++; $display("FAIL toggle_frame i=%0d: got %h required %h", i, o, e); end
    end
    checks++;
    if (vif.trigger !== 1'b1) begin failures++; $display("FAIL toggle_next_frame: got %b required 1", vif.trigger); end
  endtask

  task automatic test_async_reset();
    out_t o, e;
    int hold;
    wait_pos(0, 7);
    vif.trigger_raw = 1'b0;
    wait_pos(5, 7);
    #2 rst = 1'b0;
    #1;
    o = observe(); e = reset_vals(); checks++;
    if (o !== e) begin failures++; $display("FAIL async_mid_frame: got %h required %h", o, e); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    e = reset_vals(); e.col = '0; e.row = '0; e.vl = 1'b1;
    o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL async_restart: got %h required %h", o, e); end
    wait_pos(0, VA);
    checks++;
    if (vif.screen_reset !== 1'b1) begin failures++; $display("FAIL sr_before_reset: got %b required 1", vif.screen_reset); end
    #2 rst = 1'b0;
    #1;
    o = observe(); e = reset_vals(); checks++;
    if (o !== e) begin failures++; $display("FAIL sr_dropped: got %h required %h", o, e); end
    @(negedge clk);
    rst = 1'b1;
    hold = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (hold == 0) begin
        vif.trigger_raw = ~vif.trigger_raw;
        hold = $urandom_range(3 * DB, 1);
      end
      hold--;
      @(negedge clk);
      o = observe(); e = model_exp(); checks++;
      if (o !== e) begin failures++; $display("FAIL post_reset i=%0d: got %h required %h", i, o, e); end
    end
  endtask

  initial begin
    vif.trigger_raw = 1'b0;
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_debounce_reject();
    test_debounce_accept();
    test_toggle_at_frame_start();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_frame_ctrl.md
Name: vga_frame_ctrl

Overview:
- Upstream raster/timing stage for the pattern generator; one instance drives the display pipeline.
- Produces 640x480@60 VGA timing: hsync, vsync, valid, col, row.
- Produces the once-per-frame screen_reset strobe that advances the flash-state machine.
- Conditions the raw gun trigger (synchronise, debounce, frame-align) so the downstream stage sees a level that is stable across each screen_reset pulse.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- DEBOUNCE_CYCLES, 250000, consecutive stable clocks required to accept a trigger change (~10 ms at 25.175 MHz)

Ports:
- clk  input  1  pixel clock, 25.175 MHz
- rst  input  1  asynchronous, active-low reset
- trigger_raw  input  1  asynchronous gun trigger, active-high
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- valid  output  1  high while (col,row) is in the visible area
- col  output  10  current horizontal pixel count
- row  output  10  current line count
- screen_reset  output  1  one-clock frame strobe at start of vertical blank
- trigger  output  1  debounced, frame-aligned trigger level

Behaviour:
- Reset, clock and derived widths:
  - Single clock domain, clk.
  - rst low asynchronously forces all state immediately. Release is sampled on clk.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters:
  - col = hcount register, 0..H_TOTAL-1, increments every clk.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - row = vcount register, 0..V_TOTAL-1, wraps to 0 after V_TOTAL-1 when hcount wraps.
  - 10 bits covers both ranges; no saturation.
- Reset values:
  - hcount=H_TOTAL-1, vcount=V_TOTAL-1 (last clock of a frame).
  - hsync=1, vsync=1, valid=0, screen_reset=0, trigger=0.
  - Synchroniser flops=0, debounced level=0, debounce counter=0.
  - Consequence: the first rising edge after release presents col=0, row=0, valid=1.
- Flags:
  - All flags are registered and decoded from the next count values, so they are cycle-aligned with col/row (zero relative latency).
  - valid = (col < H_ACTIVE) && (row < V_ACTIVE).
  - hsync = 0 iff H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC, i.e. col 656..751.
  - vsync = 0 iff V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC, i.e. rows 490..491, for every clock of those lines.
  - screen_reset = 1 for exactly one clock, when col==0 && row==V_ACTIVE (480). Exactly one pulse per frame, never during the visible area.
- Trigger path:
  - 2-flop synchroniser on trigger_raw.
  - Debounce: whenever the synchronised value equals the debounced level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level toggles to the synchronised value and the counter clears.
  - Any bounce back before that point restarts the count from 0.
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - The trigger output loads the debounced level only on the clock where col==0 && row==0.
  - Trigger therefore changes at most once per frame and is constant across the screen_reset pulse at row 480, with ~480 lines of setup margin.
  - Press-to-output latency: 2 sync clocks + DEBOUNCE_CYCLES + wait to the next frame start (worst case ≤ 1 frame).
- Boundary conditions:
  - rst asserted mid-frame: all outputs go to reset values immediately. This includes dropping an in-flight screen_reset pulse and clearing a pending debounce.
  - Debounced level toggles on the same clock as col==0,row==0: trigger loads the pre-toggle level; the new level appears on the next frame.
- No other inputs; timing is free-running and never stalls.

Test Plan:
- Reset release: drive rst low 5 clks then high -> first edge col=0,row=0,valid=1,hsync=1,vsync=1,screen_reset=0,trigger=0; col=639 valid=1, col=640 valid=0.
- Line timing: observe one line -> hsync low exactly 96 clocks, first low at col=656; line period 800 clocks; row increments on col 799->0.
- Frame timing: observe 3 frames -> screen_reset pulses 1 clk wide at (col0,row480), spaced exactly 420000 clocks; vsync low 1600 clocks starting row 490; valid high 307200 clocks per frame.
- Debounce reject (DEBOUNCE_CYCLES=8): pulse trigger_raw high 5 clks, repeated glitches -> debounced level and trigger stay 0 across 2 frames.
- Debounce accept and alignment (DEBOUNCE_CYCLES=8): raise trigger_raw at row 100 and hold -> trigger stays 0 until next col0,row0 then 1, stable through that frame's screen_reset. Release at row 200 -> trigger returns to 0 at the following frame start.
- Async reset mid-operation: assert rst at row 300 col 123 with a debounce pending -> outputs take reset values within the same cycle with no clock edge; after release the sequence restarts from col0,row0 with trigger=0.
